// File: rtl/trap_filter_cfg_if.sv
// Sample, configuration and filtered-output signals of the trapezoidal filter.
// The master drives samples and config; the slave is the filter.
interface trap_filter_cfg_if #(
   parameter int DATA_W    = 12,
   parameter int OUT_W     = 16,
   parameter int MAX_DEPTH = 64,
   parameter int M_W       = 10
);
   localparam int CNT_W = $clog2(MAX_DEPTH + 1);

   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     cfg_load;
   logic [CNT_W-1:0]         cfg_k;
   logic [CNT_W-1:0]         cfg_l;
   logic [M_W-1:0]           cfg_m;
   logic [5:0]               cfg_shift;
   logic                     cfg_err;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_sat;

   modport master (
      output in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m, cfg_shift,
      input  cfg_err, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m, cfg_shift,
      output cfg_err, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/trap_filter_cfg.sv
// Runtime-programmable trapezoidal shaper: delay line, difference, two
// accumulators with pole-zero term, shifted and saturated signed output.
module trap_filter_cfg #(
   parameter int DATA_W    = 12,
   parameter int OUT_W     = 16,
   parameter int ACC_W     = 40,
   parameter int MAX_DEPTH = 64,
   parameter int M_W       = 10,
   parameter int K_DEF     = 4,
   parameter int L_DEF     = 8,
   parameter int M_DEF     = 0,
   parameter int SHIFT_DEF = 4
) (
   input  logic             clk,
   input  logic             reset,
   trap_filter_cfg_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_DEPTH + 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         k_q, l_q;
   logic [M_W-1:0]           m_q;
   logic [5:0]               shift_q;
   logic [CNT_W:0]           fill_cnt;
   logic [DATA_W-1:0]        dl [0:MAX_DEPTH];

   // v*/e* are the valid and emit tags travelling alongside each sample.
   logic                     v0, v1, v2, v3;
   logic                     e0, e1, e2, e3;
   logic signed [ACC_W-1:0]  d1, p_q, md2, s_q;

   logic                     accept, cfg_ok;
   logic [CNT_W:0]           cfg_sum, kl_sum;
   logic signed [ACC_W-1:0]  d_c, md_c, y_c;
   logic signed [ACC_W+M_W:0] prod;
   logic [5:0]               sh_eff;
   logic                     sat_hi, sat_lo;
   logic [OUT_W-1:0]         y_out;

   function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
      return $signed({{(ACC_W-DATA_W){1'b0}}, x});
   endfunction

   assign accept  = bus.in_valid && !bus.cfg_load;
   assign cfg_sum = {1'b0, bus.cfg_k} + {1'b0, bus.cfg_l};
   assign cfg_ok  = (bus.cfg_k != '0) && (bus.cfg_l >= bus.cfg_k) &&
                    (cfg_sum <= (CNT_W+1)'(MAX_DEPTH));
   assign kl_sum  = {1'b0, k_q} + {1'b0, l_q};

   // dl[0] is the newest sample, so dl[j] is x[n-j].
   assign d_c  = ext(dl[0]) - ext(dl[k_q]) - ext(dl[l_q]) + ext(dl[kl_sum[CNT_W-1:0]]);
   assign prod = (ACC_W+M_W+1)'(d1) * $signed({{ACC_W{1'b0}}, m_q});
   assign md_c = prod[ACC_W-1:0];

   assign sh_eff = (shift_q > 6'(ACC_W-1)) ? 6'(ACC_W-1) : shift_q;
   assign y_c    = s_q >>> sh_eff;
   assign sat_hi = y_c > Y_MAX;
   assign sat_lo = y_c < Y_MIN;
   assign y_out  = sat_hi ? Y_MAX[OUT_W-1:0] :
                   sat_lo ? Y_MIN[OUT_W-1:0] : y_c[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_FILL;
         k_q           <= CNT_W'(K_DEF);
         l_q           <= CNT_W'(L_DEF);
         m_q           <= M_W'(M_DEF);
         shift_q       <= 6'(SHIFT_DEF);
         fill_cnt      <= '0;
         // NOTE: the delay line is reset too, because samples before a (re)start must read as zero.
         for (int i = 0; i <= MAX_DEPTH; i++) dl[i] <= '0;
         {v0, v1, v2, v3} <= '0;
         {e0, e1, e2, e3} <= '0;
         d1            <= '0;
         p_q           <= '0;
         md2           <= '0;
         s_q           <= '0;
         bus.cfg_err   <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sat   <= 1'b0;
      end else begin
         bus.cfg_err <= bus.cfg_load && !cfg_ok;

         if (accept) begin
            for (int i = MAX_DEPTH; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= bus.in_data;
         end
         v0 <= accept;
         e0 <= (state == S_RUN);

         if (accept && state == S_FILL) begin
            fill_cnt <= fill_cnt + (CNT_W+1)'(1);
            if (fill_cnt + (CNT_W+1)'(1) == kl_sum) state <= S_RUN;
         end

         v1 <= v0;
         e1 <= e0;
         if (v0) d1 <= d_c;

         v2 <= v1;
         e2 <= e1;
         if (v1) begin
            p_q <= p_q + d1;
            md2 <= md_c;
         end

         // p_q still holds p[n] here while the next sample updates it.
         v3 <= v2;
         e3 <= e2;
         if (v2) s_q <= s_q + p_q + md2;

         bus.out_valid <= v3 && e3;
         if (v3) begin
            bus.out_data <= y_out;
            bus.out_sat  <= sat_hi || sat_lo;
         end

         // An accepted load restarts the data path; it overrides the updates above.
         if (bus.cfg_load && cfg_ok) begin
            state    <= S_FILL;
            k_q      <= bus.cfg_k;
            l_q      <= bus.cfg_l;
            m_q      <= bus.cfg_m;
            shift_q  <= bus.cfg_shift;
            fill_cnt <= '0;
            for (int i = 0; i <= MAX_DEPTH; i++) dl[i] <= '0;
            {v0, v1, v2, v3} <= '0;
            p_q           <= '0;
            s_q           <= '0;
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_trap_filter_cfg.sv
// Directed bench for trap_filter_cfg: impulse, step, gaps, saturation,
// config validation, reconfiguration and mid-stream reset.
module tb_trap_filter_cfg;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   int                      acc_q[$];
   int                      out_cyc_q[$];
   logic signed [15:0]      out_d_q[$];
   logic                    out_s_q[$];
   int                      err_total = 0;

   trap_filter_cfg_if bus ();

   trap_filter_cfg dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid) begin
         out_cyc_q.push_back(cyc);
         out_d_q.push_back(bus.out_data);
         out_s_q.push_back(bus.out_sat);
      end
      if (bus.cfg_err) err_total <= err_total + 1;
   end

   task automatic drive(input int x, input bit v);
      @(negedge clk);
      bus.cfg_load = 1'b0;
      bus.in_valid = v;
      bus.in_data  = 12'(x);
      if (v) acc_q.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1'b0);
   endtask

   task automatic load(input int k, input int l, input int m, input int sh,
                       input bit v, input int x);
      @(negedge clk);
      bus.cfg_load  = 1'b1;
      bus.cfg_k     = 7'(k);
      bus.cfg_l     = 7'(l);
      bus.cfg_m     = 10'(m);
      bus.cfg_shift = 6'(sh);
      bus.in_valid  = v;
      bus.in_data   = 12'(x);
      @(negedge clk);
      bus.cfg_load = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sat, bus.cfg_err} !== 3'b000 || bus.out_data !== 16'sd0) begin
         errors++;
         $display("FAIL reset_held: valid=%0b data=%0d sat=%0b err=%0b required all 0",
                  bus.out_valid, bus.out_data, bus.out_sat, bus.cfg_err);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sat, bus.cfg_err} !== 3'b000 || bus.out_data !== 16'sd0) begin
         errors++;
         $display("FAIL reset_release: valid=%0b data=%0d sat=%0b err=%0b required all 0",
                  bus.out_valid, bus.out_data, bus.out_sat, bus.cfg_err);
      end
   endtask

   // Impulse of 100 after k+l zeros with k=4, l=8, shift=0.
   task automatic test_impulse(input string name, input int m, input int gap,
                               input int n, input int exp[16]);
      int abase, obase, got;
      load(4, 8, m, 0, 1'b0, 0);
      abase = acc_q.size();
      obase = out_cyc_q.size();
      for (int i = 0; i < 12 + n; i++) begin
         drive((i == 12) ? 100 : 0, 1'b1);
         idle(gap);
      end
      idle(8);
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== n) begin
         errors++;
         $display("FAIL %s count: got %0d required %0d", name, got, n);
      end
      for (int i = 0; i < n && i < got; i++) begin
         checks++;
         if (int'(out_d_q[obase+i]) !== exp[i] || out_s_q[obase+i] !== 1'b0) begin
            errors++;
            $display("FAIL %s data[%0d]: got %0d sat %0b required %0d sat 0",
                     name, i, out_d_q[obase+i], out_s_q[obase+i], exp[i]);
         end
         checks++;
         if (out_cyc_q[obase+i] !== acc_q[abase+12+i] + 4) begin
            errors++;
            $display("FAIL %s latency[%0d]: out at %0d required %0d",
                     name, i, out_cyc_q[obase+i], acc_q[abase+12+i] + 4);
         end
      end
   endtask

   // Constant 100 with k=4, l=8, shift=4 settles at 3200>>>4 = 200.
   task automatic test_step(input string name, input int gap);
      int abase, obase, got;
      load(4, 8, 0, 4, 1'b0, 0);
      abase = acc_q.size();
      obase = out_cyc_q.size();
      for (int i = 0; i < 20; i++) begin
         drive(100, 1'b1);
         idle(gap);
      end
      idle(8);
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== 8) begin
         errors++;
         $display("FAIL %s count: got %0d required 8", name, got);
      end
      for (int i = 0; i < 8 && i < got; i++) begin
         checks++;
         if (out_d_q[obase+i] !== 16'sd200 || out_s_q[obase+i] !== 1'b0) begin
            errors++;
            $display("FAIL %s data[%0d]: got %0d sat %0b required 200 sat 0",
                     name, i, out_d_q[obase+i], out_s_q[obase+i]);
         end
         checks++;
         if (out_cyc_q[obase+i] !== acc_q[abase+12+i] + 4) begin
            errors++;
            $display("FAIL %s latency[%0d]: out at %0d required %0d",
                     name, i, out_cyc_q[obase+i], acc_q[abase+12+i] + 4);
         end
      end
   endtask

   // Rejected loads (k=0, l<k, k+l>MAX_DEPTH) pulse cfg_err and leave the stream
   // untouched; the sample offered with the k=0 load is dropped.
   task automatic test_bad_cfg;
      int abase, obase, got, err0;
      load(4, 8, 0, 4, 1'b0, 0);
      abase = acc_q.size();
      obase = out_cyc_q.size();
      err0  = err_total;
      for (int i = 0; i < 14; i++) drive(100, 1'b1);
      load(0, 8, 0, 4, 1'b1, 100);
      load(5, 4, 0, 4, 1'b0, 0);
      load(40, 30, 0, 4, 1'b0, 0);
      for (int i = 0; i < 6; i++) drive(100, 1'b1);
      idle(8);
      checks++;
      if (err_total - err0 !== 3) begin
         errors++;
         $display("FAIL bad_cfg err_pulses: got %0d required 3", err_total - err0);
      end
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== 8) begin
         errors++;
         $display("FAIL bad_cfg count: got %0d required 8", got);
      end
      for (int i = 0; i < 8 && i < got; i++) begin
         checks++;
         if (out_d_q[obase+i] !== 16'sd200 || out_cyc_q[obase+i] !== acc_q[abase+12+i] + 4) begin
            errors++;
            $display("FAIL bad_cfg out[%0d]: got %0d at %0d required 200 at %0d",
                     i, out_d_q[obase+i], out_cyc_q[obase+i], acc_q[abase+12+i] + 4);
         end
      end
   endtask

   // Mid-stream load of k=5, l=10: in-flight samples vanish, warm-up restarts,
   // step of 100 settles at 5000>>>4 = 312.
   task automatic test_reconfig;
      int abase, obase, got;
      load(4, 8, 0, 4, 1'b0, 0);
      for (int i = 0; i < 16; i++) drive(100, 1'b1);
      load(5, 10, 0, 4, 1'b0, 0);
      abase = acc_q.size();
      obase = out_cyc_q.size();
      for (int i = 0; i < 20; i++) drive(100, 1'b1);
      idle(8);
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== 5) begin
         errors++;
         $display("FAIL reconfig count: got %0d required 5", got);
      end
      for (int i = 0; i < 5 && i < got; i++) begin
         checks++;
         if (out_d_q[obase+i] !== 16'sd312 || out_cyc_q[obase+i] !== acc_q[abase+15+i] + 4) begin
            errors++;
            $display("FAIL reconfig out[%0d]: got %0d at %0d required 312 at %0d",
                     i, out_d_q[obase+i], out_cyc_q[obase+i], acc_q[abase+15+i] + 4);
         end
      end
   endtask

   // k=l=32, constant 4095 then zeros: s peaks at 4193280 and the decay tail
   // is 40950, 24570, 12285, 4095, 0 for samples 128..132.
   task automatic test_saturation;
      int obase, got, smp, exp_d;
      bit exp_s;
      load(32, 32, 0, 0, 1'b0, 0);
      obase = out_cyc_q.size();
      for (int i = 0; i < 70; i++) drive(4095, 1'b1);
      for (int i = 0; i < 70; i++) drive(0, 1'b1);
      idle(8);
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== 76) begin
         errors++;
         $display("FAIL sat count: got %0d required 76", got);
      end
      for (int i = 0; i < 76 && i < got; i++) begin
         smp = 64 + i;
         exp_s = (smp <= 128);
         case (smp)
            129:     exp_d = 24570;
            130:     exp_d = 12285;
            131:     exp_d = 4095;
            default: exp_d = (smp <= 128) ? 32767 : 0;
         endcase
         checks++;
         if (int'(out_d_q[obase+i]) !== exp_d || out_s_q[obase+i] !== exp_s) begin
            errors++;
            $display("FAIL sat sample %0d: got %0d sat %0b required %0d sat %0b",
                     smp, out_d_q[obase+i], out_s_q[obase+i], exp_d, exp_s);
         end
      end
   endtask

   // One-cycle reset mid-stream restores defaults (k=4, l=8, M=0, shift=4).
   task automatic test_reset_mid;
      int abase, obase, got;
      load(5, 10, 1, 0, 1'b0, 0);
      for (int i = 0; i < 18; i++) drive(100, 1'b1);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 12'd100;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sat, bus.cfg_err} !== 3'b000 || bus.out_data !== 16'sd0) begin
         errors++;
         $display("FAIL reset_mid_held: valid=%0b data=%0d sat=%0b required all 0",
                  bus.out_valid, bus.out_data, bus.out_sat);
      end
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sat} !== 2'b00 || bus.out_data !== 16'sd0) begin
         errors++;
         $display("FAIL reset_mid_release: valid=%0b data=%0d sat=%0b required all 0",
                  bus.out_valid, bus.out_data, bus.out_sat);
      end
      abase = acc_q.size();
      obase = out_cyc_q.size();
      for (int i = 0; i < 20; i++) drive(100, 1'b1);
      idle(8);
      got = out_cyc_q.size() - obase;
      checks++;
      if (got !== 8) begin
         errors++;
         $display("FAIL reset_mid count: got %0d required 8", got);
      end
      for (int i = 0; i < 8 && i < got; i++) begin
         checks++;
         if (out_d_q[obase+i] !== 16'sd200 || out_cyc_q[obase+i] !== acc_q[abase+12+i] + 4) begin
            errors++;
            $display("FAIL reset_mid out[%0d]: got %0d at %0d required 200 at %0d",
                     i, out_d_q[obase+i], out_cyc_q[obase+i], acc_q[abase+12+i] + 4);
         end
      end
   endtask

   initial begin
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.cfg_load  = 1'b0;
      bus.cfg_k     = '0;
      bus.cfg_l     = '0;
      bus.cfg_m     = '0;
      bus.cfg_shift = '0;

      test_reset();
      test_impulse("impulse", 0, 0, 12,
                   '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0, 0, 0});
      test_impulse("impulse_m1_gapped", 1, 2, 13,
                   '{200, 300, 400, 500, 400, 400, 400, 400, 200, 100, 0, -100, 0, 0, 0, 0});
      test_step("step", 0);
      test_step("step_gapped", 2);
      test_bad_cfg();
      test_reconfig();
      test_saturation();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/trap_filter_cfg.md
Name: trap_filter_cfg

Overview:
- Next-generation trapezoidal shaping filter for unsigned ADC samples.
- k, l, M and the output shift are runtime-programmable up to a compile-time maximum depth.
- Samples are qualified by a valid strobe; output is signed and saturated, with its own valid flag and a warm-up suppression.
- Sits between the ADC capture stage and the peak/energy extraction logic.

Parameters:
DATA_W, 12, ADC sample width (unsigned)
OUT_W, 16, output width (signed two's complement)
ACC_W, 40, internal accumulator width (signed)
MAX_DEPTH, 64, maximum k+l supported by the delay line
M_W, 10, width of the M multiplier coefficient (unsigned)
K_DEF, 4, k after reset
L_DEF, 8, l after reset
M_DEF, 0, M after reset
SHIFT_DEF, 4, output right-shift after reset

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  in_data accepted this cycle
in_data  in  DATA_W  ADC sample, unsigned
cfg_load  in  1  one-cycle strobe: apply cfg_* values
cfg_k  in  clog2(MAX_DEPTH+1)  rise time k
cfg_l  in  clog2(MAX_DEPTH+1)  delay l
cfg_m  in  M_W  pole-zero coefficient M
cfg_shift  in  6  arithmetic right-shift applied at output
cfg_err  out  1  one-cycle pulse: rejected cfg_load
out_valid  out  1  out_data valid this cycle
out_data  out  OUT_W  filtered sample, signed, saturated
out_sat  out  1  out_data was clipped this sample

Behaviour:
- Reset: reset low at a rising edge clears the delay line, all pipeline registers, accumulators and fill counter. Config becomes K_DEF/L_DEF/M_DEF/SHIFT_DEF and state becomes FILL. Outputs are 0 while reset is held and on the first cycle after it is released. Reset mid-stream discards all in-flight samples; none are emitted.
- Arithmetic: for accepted samples x[n], with x before the (re)start equal to 0:
  - d[n] = x[n] - x[n-k] - x[n-l] + x[n-k-l]
  - p[n] = p[n-1] + d[n]
  - r[n] = p[n] + M*d[n]
  - s[n] = s[n-1] + r[n]
  - y[n] = s[n] >>> shift
- Widths: all internal values are ACC_W signed; p and s wrap modulo 2^ACC_W. Saturation applies only at output conversion: y is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 on the same cycle if clamped, else 0.
- Delay line: MAX_DEPTH+1 entries. It shifts only when in_valid=1; taps are selected at k, l and k+l.
- Pipeline: fixed, valid-tagged and 4 stages deep.
  - out_valid for sample n asserts exactly 4 clk cycles after the cycle in which it was accepted.
  - Gaps in in_valid produce gaps in out_valid; data values are identical to a gap-free stream.
  - Accumulators update only on their stage's valid.
- State machine:
  - FILL: the filter computes normally but out_valid is forced to 0. The fill counter counts accepted samples; when k+l samples have been accepted, go to RUN. Sample k+l (0-based) and every later sample are emitted.
  - RUN: out_valid follows the pipeline valid.
- Config validation: cfg_load is accepted only if k>=1, l>=k and k+l<=MAX_DEPTH.
  - Accepted: new config is latched; delay line, pipeline valids, p, s and fill counter are cleared; state goes to FILL. In-flight samples are dropped, with no out_valid for them.
  - Rejected: cfg_err pulses one cycle later; config, state and data path are unchanged.
- Simultaneous events:
  - cfg_load and in_valid in the same cycle: cfg_load wins and that sample is discarded, whether the load is accepted or rejected.
  - reset low overrides everything.
- Shift: cfg_shift values above ACC_W-1 are treated as ACC_W-1.

Test Plan:
- Impulse, defaults (k=4, l=8, M=0, shift=0 via cfg_load): feed 12 zeros, then one sample 100, then zeros. Emitted s sequence is 100,200,300,400,400,400,400,400,300,200,100,0; out_valid first asserts 4 cycles after the 13th accepted sample.
- Step, k=4, l=8, M=0, shift=4: feed a constant 100 after warm-up. Output settles at 3200>>>4 = 200 and stays there; out_sat=0.
- Gapped input: same as the step test with in_valid toggling 1,0,0,1,...; the out_valid-qualified data sequence is identical to the gap-free run.
- Saturation, OUT_W=16, k=32, l=32, shift=0, constant 4095: s reaches 4193280, out_data=32767 and out_sat=1 while clipped. Then feed zeros: the output falls back to 0 and out_sat returns to 0.
- Config handling:
  - cfg_load with k=0: cfg_err pulses once and the stream continues uninterrupted.
  - cfg_load with k=5, l=10 mid-stream: out_valid is low for the next 15 accepted samples plus 4 cycles of latency, then resumes.
- Reset low for one cycle mid-stream: all outputs are 0, the next out_valid appears only after K_DEF+L_DEF=12 accepted samples plus 4 cycles, and in-flight data never appears.
